// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: collective-control elevator for N floors with tick-timed travel and door.
// Define ELEVATOR_FIRE_RECALL_EN to add the fire_recall input.
module elevator_ctrl_n #(
   parameter int N            = 5,
   parameter int TICK_DIV     = 50000000,
   parameter int TRAVEL_TICKS = 2,
   parameter int DOOR_TICKS   = 10
) (
   input  logic       board_clk,
   input  logic       reset,
   input  logic [N:1] car_button,
   input  logic [N:1] hall_up,
   input  logic [N:1] hall_down,
   input  logic       open_button,
   input  logic       close_button,
   input  logic       door_obstruct,
`ifdef ELEVATOR_FIRE_RECALL_EN
   input  logic       fire_recall,
`endif
   output logic [3:0] floor_num,
   output logic       door_open,
   output logic       go_up_led,
   output logic       go_down_led,
   output logic [N:1] car_led,
   output logic [N:1] led_up,
   output logic [N:1] led_down,
   output logic       busy
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int TW = $clog2(TRAVEL_TICKS + 1);
   localparam int DW = $clog2(DOOR_TICKS + 1);
   localparam logic [N:1] UP_OK = {1'b0, {(N - 1){1'b1}}};
   localparam logic [N:1] DN_OK = {{(N - 1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {IDLE, MOVE, OPEN} state_t;

   state_t        state, state_n;
   logic          dir, dir_n, fr, tick, at_end, step, stop, ahead, behind, here, match, op;
   logic [PW-1:0] pre;
   logic [TW-1:0] trav;
   logic [DW-1:0] door;
   logic [3:0]    floor_n, nf, tf;
   logic [N:1]    car_r, up_r, dn_r, all_r, fm;

`ifdef ELEVATOR_FIRE_RECALL_EN
   assign fr = fire_recall;
`else
   assign fr = 1'b0;
`endif

   function automatic logic [N:1] sel(input logic [3:0] f);
      logic [N:1] m;
      for (int i = 1; i <= N; i++) m[i] = 4'(i) == f;
      return m;
   endfunction

   function automatic logic [N:1] beyond(input logic [3:0] f, input logic up);
      logic [N:1] m;
      for (int i = 1; i <= N; i++) m[i] = up ? 4'(i) > f : 4'(i) < f;
      return m;
   endfunction

   // tf is the floor the car occupies after this edge: arrival decisions look at the new floor
   assign tick   = pre == PW'(TICK_DIV - 1);
   assign at_end = dir ? floor_num == 4'(N) : floor_num == 4'd1;
   assign step   = state == MOVE && !at_end && tick && trav == TW'(TRAVEL_TICKS - 1);
   assign nf     = dir ? floor_num + 4'd1 : floor_num - 4'd1;
   assign tf     = step ? nf : floor_num;
   assign all_r  = car_r | up_r | dn_r;
   assign fm     = sel(tf);
   assign ahead  = |(all_r & beyond(tf, dir));
   assign behind = |(all_r & beyond(tf, !dir));
   assign here   = |(all_r & fm);
   assign match  = |((car_r | (dir ? up_r : dn_r)) & fm);
   assign stop   = fr ? nf == 4'd1 : match || !ahead;
   assign op     = state_n == OPEN && !fr;

   always_comb begin
      state_n = state;
      dir_n   = dir;
      floor_n = floor_num;
      unique case (state)
         IDLE:
            if (fr) begin
               state_n = floor_num == 4'd1 ? OPEN : MOVE;
               dir_n   = 1'b0;
            end else if (here || open_button) state_n = OPEN;
            else if (ahead) state_n = MOVE;
            else if (behind) begin
               state_n = MOVE;
               dir_n   = !dir;
            end
         MOVE:
            if (at_end) state_n = IDLE;
            else if (step) begin
               floor_n = nf;
               state_n = stop ? OPEN : MOVE;
               if (fr) dir_n = 1'b0;
            end
         OPEN:
            if (fr) begin
               state_n = floor_num == 4'd1 ? OPEN : MOVE;
               dir_n   = 1'b0;
            end else if (!(door_obstruct || open_button) && (close_button || (tick && door <= DW'(1))))
               state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (op && !ahead && behind) dir_n = !dir;
   end

   always_ff @(posedge board_clk)
      if (reset) begin
         state     <= IDLE;
         dir       <= 1'b1;
         floor_num <= 4'd1;
         pre       <= '0;
         trav      <= '0;
         door      <= '0;
         car_r     <= '0;
         up_r      <= '0;
         dn_r      <= '0;
      end else begin
         state     <= state_n;
         dir       <= dir_n;
         floor_num <= floor_n;
         pre       <= tick ? '0 : pre + 1'b1;
         trav      <= state != MOVE || step ? '0 : trav + TW'(tick);
         door      <= state_n != OPEN ? '0 :
                      state != OPEN || fr || open_button || door_obstruct ? DW'(DOOR_TICKS) : door - DW'(tick);
         car_r     <= fr ? '0 : (car_r | car_button) & ~(op ? fm : '0);
         up_r      <= fr ? '0 : (up_r | (hall_up & UP_OK)) & ~(op && (dir || !ahead) ? fm : '0);
         dn_r      <= fr ? '0 : (dn_r | (hall_down & DN_OK)) & ~(op && (!dir || !ahead) ? fm : '0);
      end

   assign door_open   = state == OPEN;
   assign go_up_led   = state == MOVE && dir;
   assign go_down_led = state == MOVE && !dir;
   assign car_led     = car_r;
   assign led_up      = up_r;
   assign led_down    = dn_r;
   assign busy        = state != IDLE || |all_r;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: directed scenarios; every change of the visible outputs is an event
// checked against a queue of hand-computed expected events (value and cycle gap).
module tb_elevator_ctrl_n;
   localparam int N = 5;

   typedef struct packed {
      logic [3:0] fl;
      logic       door, up, dn, busy;
      logic [N:1] car, lu, ld;
   } snap_t;
   typedef struct {
      snap_t s;
      int    dt;
   } exp_t;

   logic       board_clk = 1'b0, reset = 1'b1;
   logic [N:1] car_button = '0, hall_up = '0, hall_down = '0;
   logic       open_button = 1'b0, close_button = 1'b0, door_obstruct = 1'b0;
`ifdef ELEVATOR_FIRE_RECALL_EN
   logic       fire_recall = 1'b0;
`endif
   logic [3:0] floor_num;
   logic       door_open, go_up_led, go_down_led, busy;
   logic [N:1] car_led, led_up, led_down;

   exp_t  q[$];
   exp_t  e;
   snap_t prev = '1, cur;
   int    tests = 0, fails = 0, cyc = 0, last = 0;
   logic  mon_en = 1'b0;

   elevator_ctrl_n #(.N(N), .TICK_DIV(4), .TRAVEL_TICKS(2), .DOOR_TICKS(3)) dut (
      .board_clk(board_clk), .reset(reset), .car_button(car_button), .hall_up(hall_up),
      .hall_down(hall_down), .open_button(open_button), .close_button(close_button),
      .door_obstruct(door_obstruct),
`ifdef ELEVATOR_FIRE_RECALL_EN
      .fire_recall(fire_recall),
`endif
      .floor_num(floor_num), .door_open(door_open), .go_up_led(go_up_led),
      .go_down_led(go_down_led), .car_led(car_led), .led_up(led_up), .led_down(led_down),
      .busy(busy)
   );

   initial forever #5 board_clk = ~board_clk;
   always @(posedge board_clk) cyc <= cyc + 1;

   function automatic void ex(input logic [3:0] fl, input logic door, input logic up,
                              input logic dn, input logic bz, input logic [N:1] car,
                              input logic [N:1] lu, input logic [N:1] ld, input int dt);
      exp_t x;
      x.s  = {fl, door, up, dn, bz, car, lu, ld};
      x.dt = dt;
      q.push_back(x);
   endfunction

   task automatic at(input int n);
      while (cyc < n) begin
         @(posedge board_clk);
         #1;
      end
   endtask

   always @(negedge board_clk)
      if (mon_en) begin
         cur = {floor_num, door_open, go_up_led, go_down_led, busy, car_led, led_up, led_down};
         if (cur !== prev) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_event cycle %0d: got %h", cyc, cur);
            end else begin
               e = q.pop_front();
               if (cur !== e.s || (e.dt != 0 && cyc - last != e.dt)) begin
                  fails++;
                  $display("FAIL event_%0d cycle %0d: got %h gap %0d, expected %h gap %0d",
                           tests, cyc, cur, cyc - last, e.s, e.dt);
               end
            end
            prev = cur;
            last = cyc;
         end
      end

   initial begin
      // reset state, then car call to floor 4 from floor 1
      ex(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0);
      ex(1, 0, 0, 0, 1, 5'b01000, 5'b00000, 5'b00000, 1);
      ex(1, 0, 1, 0, 1, 5'b01000, 5'b00000, 5'b00000, 1);
      ex(2, 0, 1, 0, 1, 5'b01000, 5'b00000, 5'b00000, 6);
      ex(3, 0, 1, 0, 1, 5'b01000, 5'b00000, 5'b00000, 8);
      ex(4, 1, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 8);
      ex(4, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 12);
      at(2);  reset = 1'b0; mon_en = 1'b1; car_button = 5'b01000;
      at(3);  car_button = '0;
      // opposite hall call at 3 is skipped on the way up, served after reversing at 5
      ex(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 2);
      ex(1, 0, 0, 0, 1, 5'b10000, 5'b00000, 5'b00000, 1);
      ex(1, 0, 1, 0, 1, 5'b10000, 5'b00000, 5'b00000, 1);
      ex(2, 0, 1, 0, 1, 5'b10000, 5'b00000, 5'b00000, 6);
      ex(2, 0, 1, 0, 1, 5'b10000, 5'b00000, 5'b00100, 1);
      ex(3, 0, 1, 0, 1, 5'b10000, 5'b00000, 5'b00100, 7);
      ex(4, 0, 1, 0, 1, 5'b10000, 5'b00000, 5'b00100, 8);
      ex(5, 1, 0, 0, 1, 5'b00000, 5'b00000, 5'b00100, 8);
      ex(5, 0, 0, 0, 1, 5'b00000, 5'b00000, 5'b00100, 12);
      ex(5, 0, 0, 1, 1, 5'b00000, 5'b00000, 5'b00100, 1);
      ex(4, 0, 0, 1, 1, 5'b00000, 5'b00000, 5'b00100, 7);
      ex(3, 1, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 8);
      ex(3, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 12);
      at(39); reset = 1'b1;
      at(40); reset = 1'b0; car_button = 5'b10000;
      at(41); car_button = '0;
      at(48); hall_down = 5'b00100;
      at(49); hall_down = '0;
      // same-direction hall call at 3 stops the car, then it continues to 5
      ex(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 2);
      ex(1, 0, 0, 0, 1, 5'b10000, 5'b00100, 5'b00000, 1);
      ex(1, 0, 1, 0, 1, 5'b10000, 5'b00100, 5'b00000, 1);
      ex(2, 0, 1, 0, 1, 5'b10000, 5'b00100, 5'b00000, 6);
      ex(3, 1, 0, 0, 1, 5'b10000, 5'b00000, 5'b00000, 8);
      ex(3, 0, 0, 0, 1, 5'b10000, 5'b00000, 5'b00000, 12);
      ex(3, 0, 1, 0, 1, 5'b10000, 5'b00000, 5'b00000, 1);
      ex(4, 0, 1, 0, 1, 5'b10000, 5'b00000, 5'b00000, 7);
      ex(5, 1, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 8);
      ex(5, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 12);
      at(113); reset = 1'b1;
      at(114); reset = 1'b0; car_button = 5'b10000; hall_up = 5'b00100;
      at(115); car_button = '0; hall_up = '0;
      // open button, obstruction beats close, close alone, ignored end-floor hall buttons
      ex(5, 1, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 2);
      ex(5, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 30);
      ex(5, 1, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 2);
      ex(5, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1);
      at(171); open_button = 1'b1;
      at(172); open_button = 1'b0; door_obstruct = 1'b1; close_button = 1'b1;
      at(192); door_obstruct = 1'b0; close_button = 1'b0;
      at(203); open_button = 1'b1;
      at(204); open_button = 1'b0; close_button = 1'b1;
      at(205); close_button = 1'b0; hall_up = 5'b10000; hall_down = 5'b00001;
      at(206); hall_up = '0; hall_down = '0;
      // reset abandons travel between floors 2 and 3
      ex(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 3);
      ex(1, 0, 0, 0, 1, 5'b01000, 5'b00000, 5'b00000, 1);
      ex(1, 0, 1, 0, 1, 5'b01000, 5'b00000, 5'b00000, 1);
      ex(2, 0, 1, 0, 1, 5'b01000, 5'b00000, 5'b00000, 6);
      ex(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 6);
      at(207); reset = 1'b1;
      at(208); reset = 1'b0; car_button = 5'b01000; hall_up = 5'b10000; hall_down = 5'b00001;
      at(209); car_button = '0; hall_up = '0; hall_down = '0;
      at(221); reset = 1'b1;
      at(222); reset = 1'b0;
`ifdef ELEVATOR_FIRE_RECALL_EN
      // fire recall mid-ascent: finish the step, return to 1, hold door until released
      ex(1, 0, 0, 0, 1, 5'b01000, 5'b00000, 5'b00000, 3);
      ex(1, 0, 1, 0, 1, 5'b01000, 5'b00000, 5'b00000, 1);
      ex(2, 0, 1, 0, 1, 5'b01000, 5'b00000, 5'b00000, 8);
      ex(2, 0, 1, 0, 1, 5'b00000, 5'b00000, 5'b00000, 2);
      ex(3, 0, 0, 1, 1, 5'b00000, 5'b00000, 5'b00000, 6);
      ex(2, 0, 0, 1, 1, 5'b00000, 5'b00000, 5'b00000, 8);
      ex(1, 1, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000, 8);
      ex(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 52);
      at(224); car_button = 5'b01000;
      at(225); car_button = '0;
      at(235); fire_recall = 1'b1; car_button = 5'b10000;
      at(236); car_button = '0;
      at(270); close_button = 1'b1;
      at(272); close_button = 1'b0;
      at(299); fire_recall = 1'b0;
      at(320);
`else
      at(232);
`endif
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL missing_events: %0d still queued, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
